// File: rtl/uart_echo.sv
// uart_echo: 8N1 UART receiver looped back into a transmitter through a 1-entry holding register.
// Optional UART_FRAMING_CHECK_EN drops frames whose stop bit samples low.
module uart_echo #(
    parameter int CLKS_PER_BIT = 18
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       receive,
    output logic       transmit,
    output logic [7:0] data
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic sync1_q, sync2_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, turn_q, turn_d;
    logic [2:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d, data_q, data_d;
    logic hold_full_q, hold_full_d, tx_q, tx_d;
    logic rx_done, stop_ok;

`ifdef UART_FRAMING_CHECK_EN
    assign stop_ok = sync2_q;
`else
    assign stop_ok = 1'b1;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d = rx_cnt_q + CW'(1);
        rx_bit_d = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                rx_state_d = sync2_q ? IDLE : START;
            end
            START: if (rx_cnt_q == HALF_END) begin
                rx_cnt_d = '0;
                rx_state_d = sync2_q ? IDLE : DATA;
            end
            DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d = '0;
                rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                rx_state_d = (rx_bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (rx_cnt_q == BIT_END) begin
                rx_done = stop_ok;
                rx_state_d = IDLE;
            end
        endcase
    end

    // turn_q counts the turnaround from the latest holding-register write
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d = tx_cnt_q + CW'(1);
        tx_bit_d = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d = tx_q;
        hold_full_d = hold_full_q;
        hold_d = hold_q;
        data_d = data_q;
        turn_d = (turn_q == BIT_END) ? turn_q : turn_q + CW'(1);
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (hold_full_q && turn_q == BIT_END) begin
                    tx_state_d = START;
                    tx_shift_d = hold_q;
                    hold_full_d = 1'b0;
                    tx_d = 1'b0;
                end
            end
            START: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0;
                tx_state_d = DATA;
                tx_d = tx_shift_q[0];
            end
            DATA: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 3'd1;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_d = (tx_bit_q == 3'd7) ? 1'b1 : tx_shift_q[1];
                tx_state_d = (tx_bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (tx_cnt_q == BIT_END) tx_state_d = IDLE;
        endcase
        if (rx_done) begin
            hold_full_d = 1'b1;
            hold_d = rx_shift_q;
            turn_d = '0;
            data_d = rx_shift_q;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_shift_q <= '0;
            tx_state_q <= IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_shift_q <= '0;
            tx_q <= 1'b1;
            hold_q <= '0;
            hold_full_q <= 1'b0;
            turn_q <= '0;
            data_q <= '0;
        end else begin
            sync1_q <= receive;
            sync2_q <= sync1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bit_q <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q <= tx_d;
            hold_q <= hold_d;
            hold_full_q <= hold_full_d;
            turn_q <= turn_d;
            data_q <= data_d;
        end
    end

    assign transmit = tx_q;
    assign data = data_q;
endmodule

// File: tb/tb_uart_echo.sv
// tb_uart_echo: directed and random UART frames, checked every cycle against a frame-level echo model.
module tb_uart_echo;
    localparam int CPB = 18;
    // start-bit fall to stop-bit sample: 2-flop sync + detect, half bit, then nine whole bits
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    typedef struct {
        int         t;
        logic [7:0] b;
        logic       ok;
    } ev_t;

    logic clock = 1'b0, clear = 1'b0, receive = 1'b1;
    logic transmit;
    logic [7:0] data;
    int checks = 0, failures = 0, ncyc = 0;
    ev_t evq[$];
    logic hold_v = 1'b0, exp_tx = 1'b1;
    logic [7:0] hold_b = '0, tx_byte = '0, exp_data = '0;
    int hold_w = 0, tx_start = -1000000, tx_free = 0;

    uart_echo #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .clear(clear), .receive(receive), .transmit(transmit), .data(data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, ncyc, act, exp);
        end
    endtask

    function automatic logic frame_bit(input int c);
        int k = (c - tx_start) / CPB;
        if (c < tx_start || k > 9) return 1'b1;
        return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tx_byte[k-1];
    endfunction

    // Model: a byte becomes visible LAT cycles after its start bit; the echo frame starts once the
    // byte is CPB cycles old and the previous frame (10 bits plus one idle cycle) has finished.
    always @(negedge clock) begin : model
        ev_t e;
        if (!clear) begin
            evq.delete();
            hold_v = 1'b0;
            tx_start = -1000000;
            tx_free = 0;
            exp_data = '0;
        end else begin
            if (hold_v && ncyc >= hold_w + CPB && ncyc >= tx_free) begin
                tx_start = ncyc;
                tx_byte = hold_b;
                tx_free = ncyc + 10 * CPB + 1;
                hold_v = 1'b0;
            end
            while (evq.size() > 0 && evq[0].t <= ncyc) begin
                e = evq.pop_front();
                if (e.ok) begin
                    hold_v = 1'b1;
                    hold_b = e.b;
                    hold_w = ncyc;
                    exp_data = e.b;
                end
            end
        end
        exp_tx = frame_bit(ncyc);
        check("data", {2'b00, data}, {2'b00, exp_data});
        check("transmit", {9'd0, transmit}, {9'd0, exp_tx});
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic sb);
        logic [9:0] f;
        f = {sb, b, 1'b0};
`ifdef UART_FRAMING_CHECK_EN
        evq.push_back('{ncyc + LAT, b, sb});
`else
        evq.push_back('{ncyc + LAT, b, 1'b1});
`endif
        for (int i = 0; i < 10; i++) begin
            receive = f[i];
            repeat (CPB) @(negedge clock);
        end
        receive = 1'b1;
    endtask

    task automatic tx_capture(input logic [9:0] exp, input string name);
        logic [9:0] got;
        int n = 0;
        while (transmit !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL %s: no start bit within 400 cycles, expected frame %b", name, exp);
            return;
        end
        repeat (CPB / 2) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            got[i] = transmit;
            if (i < 9) repeat (CPB) @(negedge clock);
        end
        check(name, got, exp);
    endtask

    initial begin
        logic [7:0] b;
        logic sb;
        idle(10);
        check("reset_data", {2'b00, data}, 10'h000);
        check("reset_tx", {9'd0, transmit}, 10'h001);
        @(posedge clock);
        #2 clear = 1'b1;
        @(negedge clock);
        send_frame(8'h55, 1'b1);
        check("data_55", {2'b00, data}, 10'h055);
        tx_capture(10'b1010101010, "echo_55");
        send_frame(8'h00, 1'b1);
        check("data_00", {2'b00, data}, 10'h000);
        tx_capture(10'b1000000000, "echo_00");
        send_frame(8'hFF, 1'b1);
        check("data_ff", {2'b00, data}, 10'h0FF);
        tx_capture(10'b1111111110, "echo_ff");
        send_frame(8'h66, 1'b1);
        check("data_66", {2'b00, data}, 10'h066);
        tx_capture(10'b1011001100, "echo_66");
        idle(20);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(400);
        check("b2b_data", {2'b00, data}, 10'h0FF);
        receive = 1'b0;
        idle(4);
        receive = 1'b1;
        idle(60);
        check("glitch_data", {2'b00, data}, 10'h0FF);
        send_frame(8'hA5, 1'b0);
        idle(400);
`ifdef UART_FRAMING_CHECK_EN
        check("framing_data", {2'b00, data}, 10'h0FF);
`else
        check("framing_data", {2'b00, data}, 10'h0A5);
`endif
        send_frame(8'h3C, 1'b1);
        idle(60);
        @(posedge clock);
        #2 clear = 1'b0;
        idle(5);
        check("midrst_data", {2'b00, data}, 10'h000);
        check("midrst_tx", {9'd0, transmit}, 10'h001);
        @(posedge clock);
        #2 clear = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 25; i++) begin
            b = 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            send_frame(b, sb);
            idle(sb ? $urandom_range(0, 1) * $urandom_range(0, 30) : 30 + $urandom_range(0, 20));
        end
        idle(600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
